// File: rtl/fetch_sequencer_if.sv
// Instruction ROM bus between the fetch sequencer (master) and the ROM (slave).
// The ROM returns rom_data combinationally from rom_addr.
interface fetch_sequencer_if;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Three-cycle fetch/decode/execute sequencer for an 8-bit instruction ROM.
// Optional feature: define SINGLE_STEP_EN to add a single-instruction step input.
//
// state   | meaning
// IDLE    | waiting for run (or step); pc held
// FETCH   | ir <= ROM byte at pc
// DECODE  | opcode visible; HLT goes to HALT
// EXECUTE | one strobe by opcode, pc += 1, then FETCH or back to IDLE
// HALT    | locked until reset
module fetch_sequencer (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
`ifdef SINGLE_STEP_EN
    input  logic                     step,
`endif
    fetch_sequencer_if.master        rom,
    output logic [3:0]               opcode,
    output logic [3:0]               operand,
    output logic                     ld_a,
    output logic                     ld_b,
    output logic                     alu_sub,
    output logic                     st_out,
    output logic                     busy,
    output logic                     halted,
    output logic [7:0]               pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_LDB = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OUT = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
`ifdef SINGLE_STEP_EN
    logic       step_q, step_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
`ifdef SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef SINGLE_STEP_EN
            step_q  <= step_d;
`endif
        end
    end

    // Strobes decode from the registered state and ir, never from rom_data.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        alu_sub = 1'b0;
        st_out  = 1'b0;
`ifdef SINGLE_STEP_EN
        step_d  = step_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
`ifdef SINGLE_STEP_EN
                else if (step) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
`endif
            end
            S_FETCH: begin
                ir_d    = rom.rom_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (ir_q[7:4] == OP_HLT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                pc_d = pc_q + 8'd1;
                case (ir_q[7:4])
                    OP_LDA:  ld_a    = 1'b1;
                    OP_LDB:  ld_b    = 1'b1;
                    OP_SUB:  alu_sub = 1'b1;
                    OP_OUT:  st_out  = 1'b1;
                    default: ;
                endcase
`ifdef SINGLE_STEP_EN
                if (step_q) begin
                    state_d = S_IDLE;
                    step_d  = 1'b0;
                end else
`endif
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom.rom_addr = pc_q;
    assign pc           = pc_q;
    assign opcode       = ir_q[7:4];
    assign operand      = ir_q[3:0];
    assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE);
    assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: full run, pause, wrap,
// reset mid-execute, halt lock and (with SINGLE_STEP_EN) single step.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif
    logic [3:0] opcode, operand;
    logic       ld_a, ld_b, alu_sub, st_out, busy, halted;
    logic [7:0] pc;
    logic [7:0] rom [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if rom_if ();
    assign rom_if.rom_data = rom[rom_if.rom_addr];

    fetch_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
`ifdef SINGLE_STEP_EN
        .step    (step),
`endif
        .rom     (rom_if),
        .opcode  (opcode),
        .operand (operand),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .alu_sub (alu_sub),
        .st_out  (st_out),
        .busy    (busy),
        .halted  (halted),
        .pc      (pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int n_strobes();
        return int'(ld_a) + int'(ld_b) + int'(alu_sub) + int'(st_out);
    endfunction

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < 256; i++) rom[i] = val;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
`ifdef SINGLE_STEP_EN
        step  = 1'b0;
`endif
        @(negedge clk);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic load_prog();
        fill_rom(8'hF0);
        rom[0] = 8'h03;
        rom[1] = 8'h11;
        rom[2] = 8'h30;
        rom[3] = 8'h60;
        rom[4] = 8'hF0;
    endtask

    initial begin
        int t_a, t_b, t_s, t_o, o_a, o_b, o_s, o_o, nstb, multi, bad, busylow, badinc, wraps;
        logic [7:0] prev;

        // Full program run, then halt lock
        load_prog();
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_strobes", n_strobes(), 0);
        t_a = -1; t_b = -1; t_s = -1; t_o = -1;
        o_a = -1; o_b = -1; o_s = -1; o_o = -1;
        nstb = 0; multi = 0;
        run = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            if (n_strobes() > 1) multi++;
            nstb += n_strobes();
            if (ld_a)    begin t_a = c; o_a = int'(operand); end
            if (ld_b)    begin t_b = c; o_b = int'(operand); end
            if (alu_sub) begin t_s = c; o_s = int'(operand); end
            if (st_out)  begin t_o = c; o_o = int'(operand); end
        end
        chk("run_lda_cyc", t_a, 3);
        chk("run_lda_opnd", o_a, 3);
        chk("run_ldb_cyc", t_b, 6);
        chk("run_ldb_opnd", o_b, 1);
        chk("run_sub_cyc", t_s, 9);
        chk("run_sub_opnd", o_s, 0);
        chk("run_out_cyc", t_o, 12);
        chk("run_out_opnd", o_o, 0);
        chk("run_nstrobes", nstb, 4);
        chk("run_multi", multi, 0);
        chk("run_halted", halted, 1);
        chk("run_pc", pc, 8'h04);
        chk("run_busy", busy, 0);

        nstb = 0; bad = 0;
        for (int c = 0; c < 10; c++) begin
            run = ~run;
            cyc();
            nstb += n_strobes();
            if (!halted || busy || pc != 8'h04) bad++;
        end
        chk("halt_strobes", nstb, 0);
        chk("halt_bad", bad, 0);

        // Pause at an instruction boundary
        load_prog();
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 5; c++) cyc();
        chk("pause_dec_busy", busy, 1);
        chk("pause_dec_pc", pc, 8'h01);
        chk("pause_dec_opcode", opcode, 4'h1);
        run = 1'b0;
        cyc();
        chk("pause_ldb", ld_b, 1);
        cyc();
        chk("pause_idle_busy", busy, 0);
        chk("pause_idle_pc", pc, 8'h02);
        chk("pause_idle_strobes", n_strobes(), 0);
        cyc();
        cyc();
        chk("pause_hold_pc", pc, 8'h02);
        chk("pause_hold_busy", busy, 0);
        run = 1'b1;
        cyc();
        cyc();
        chk("resume_pre_sub", alu_sub, 0);
        cyc();
        chk("resume_sub", alu_sub, 1);
        chk("resume_opcode", opcode, 4'h3);

        // Reset asserted in the EXECUTE cycle of ld_a
        load_prog();
        do_reset();
        run = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("midrst_lda", ld_a, 1);
        rst_n = 1'b0;
        cyc();
        chk("midrst_lda_off", ld_a, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_opcode", opcode, 0);
        chk("midrst_operand", operand, 0);
        chk("midrst_halted", halted, 0);
        rst_n = 1'b1;
        run   = 1'b0;

        // All-NOP program: pc wraps 0xFF -> 0x00
        fill_rom(8'h20);
        do_reset();
        run = 1'b1;
        prev = 8'h00; nstb = 0; busylow = 0; badinc = 0; wraps = 0;
        for (int c = 1; c <= 800; c++) begin
            cyc();
            nstb += n_strobes();
            if (!busy) busylow++;
            if (pc != prev) begin
                if (pc != prev + 8'd1) badinc++;
                if (pc == 8'h00) wraps++;
                prev = pc;
            end
        end
        chk("wrap_strobes", nstb, 0);
        chk("wrap_busylow", busylow, 0);
        chk("wrap_badinc", badinc, 0);
        chk("wrap_count", wraps, 1);
        chk("wrap_pc", pc, 8'h0A);

`ifdef SINGLE_STEP_EN
        // One step pulse executes exactly one instruction
        load_prog();
        do_reset();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        cyc();
        chk("step_lda", ld_a, 1);
        cyc();
        chk("step_idle_busy", busy, 0);
        chk("step_pc", pc, 8'h01);
        nstb = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            nstb += n_strobes();
        end
        chk("step_no_more", nstb, 0);
        chk("step_pc_hold", pc, 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
